// File: rtl/axi_llc_pkg.sv
// Shared LLC SRAM helpers, so the request controller and the SRAM macro wrapper
// derive the read latency from the same output-cut count.
package axi_llc_pkg;

    function automatic int unsigned sram_rd_latency(input int unsigned num_output_cuts);
        return num_output_cuts + 32'd1;
    endfunction

endpackage

// File: rtl/axi_llc_sram_rsp_fifo.sv
// Non-fall-through circular response buffer: a pushed word becomes visible
// on the next cycle. Push and pop may happen in the same cycle, including when full.
module axi_llc_sram_rsp_fifo #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;

    logic [DataWidth-1:0] mem_q [Depth];
    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic                 full, push, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full    = (count_q == CntWidth'(Depth));
    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign pop     = pop_i & valid_o;
    assign push    = push_i & (~full | pop);

    // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is read only after a push has written it.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdata_i;
    end

    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop_i));

endmodule

// File: rtl/axi_llc_sram_req_ctrl.sv
// Valid/ready to SRAM req/gnt adapter. Reads are credit-limited against the response
// FIFO, so every word returning after the fixed SRAM latency has a slot waiting.
module axi_llc_sram_req_ctrl
    import axi_llc_pkg::*;
#(
    parameter  int unsigned NumWords     = 1024,
    parameter  int unsigned DataWidth    = 128,
    parameter  int unsigned ByteWidth    = 8,
    parameter  int unsigned Latency      = sram_rd_latency(0),
    parameter  int unsigned RspFifoDepth = 2,
    localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic                 sram_gnt_i,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 idle_o
);

    localparam int unsigned CntWidth = $clog2(RspFifoDepth + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [Latency-1:0]  rd_pipe_q, rd_pipe_d;
    logic [Latency:0]    rd_pipe_in;
    logic                credit_ok, rd_hs, fifo_push, fifo_pop;

    // cnt covers reads in flight plus buffered words; the pop credit is seen next cycle.
    assign credit_ok    = req_we_i | (cnt_q < CntWidth'(RspFifoDepth));
    assign sram_req_o   = req_valid_i & credit_ok;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;
    assign req_ready_o  = credit_ok & sram_gnt_i;

    assign rd_hs      = req_valid_i & req_ready_o & ~req_we_i;
    assign rd_pipe_in = {rd_pipe_q, rd_hs};
    assign fifo_push  = rd_pipe_q[Latency-1];
    assign fifo_pop   = rsp_valid_o & rsp_ready_i;
    assign idle_o     = (cnt_q == '0);

    always_comb begin
        rd_pipe_d = rd_pipe_in[Latency-1:0];
        case ({rd_hs, fifo_pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rd_pipe_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    axi_llc_sram_rsp_fifo #(
        .Depth     (RspFifoDepth),
        .DataWidth (DataWidth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (sram_rdata_i),
        .pop_i   (fifo_pop),
        .valid_o (rsp_valid_o),
        .rdata_o (rsp_rdata_o)
    );

endmodule

// File: tb/tb_axi_llc_sram_req_ctrl.sv
// Directed bench: instance a (Latency 1, depth 2) and instance b (Latency 3, depth 4),
// each fed by a small SRAM model whose read data is a fixed function of the address.
module tb_axi_llc_sram_req_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] fdata(input logic [9:0] a);
        return {118'b0, a} ^ 128'hB5;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic         a_valid, a_ready, a_we, a_sram_req, a_sram_we, a_gnt;
    logic         a_rsp_valid, a_rsp_ready, a_idle;
    logic [9:0]   a_addr, a_sram_addr, a_pa_q;
    logic [127:0] a_wdata, a_sram_wdata, a_rdata, a_rsp_rdata;
    logic [15:0]  a_be, a_sram_be;

    logic         b_valid, b_ready, b_we, b_sram_req, b_sram_we, b_gnt;
    logic         b_rsp_valid, b_rsp_ready, b_idle;
    logic [9:0]   b_addr, b_sram_addr;
    logic [9:0]   b_pa_q [3];
    logic [127:0] b_wdata, b_sram_wdata, b_rdata, b_rsp_rdata;
    logic [15:0]  b_be, b_sram_be;

    // SRAM models: address pipelines of the instance's latency, not reset by rst
    always @(posedge clk) begin
        a_pa_q    <= a_sram_addr;
        b_pa_q[0] <= b_sram_addr;
        b_pa_q[1] <= b_pa_q[0];
        b_pa_q[2] <= b_pa_q[1];
    end
    assign a_rdata = fdata(a_pa_q);
    assign b_rdata = fdata(b_pa_q[2]);

    axi_llc_sram_req_ctrl #(.Latency(1), .RspFifoDepth(2)) u_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be),
        .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
        .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_gnt_i(a_gnt),
        .sram_rdata_i(a_rdata), .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .idle_o(a_idle)
    );

    axi_llc_sram_req_ctrl #(.Latency(3), .RspFifoDepth(4)) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be),
        .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
        .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_gnt_i(b_gnt),
        .sram_rdata_i(b_rdata), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .idle_o(b_idle)
    );

    initial begin
        logic [8:0]  b_rdy_exp;
        logic [12:0] b_vld_exp;
        int          issued;
        int          popped;

        rst = 1'b1;
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '1; a_gnt = 1; a_rsp_ready = 0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = 128'h1234; b_be = 16'h00F0; b_gnt = 1; b_rsp_ready = 0;

        // Reset state
        mid();
        check("rst_rsp_valid", 128'(a_rsp_valid), 128'd0);
        check("rst_idle", 128'(a_idle), 128'd1);
        check("rst_sram_req", 128'(a_sram_req), 128'd0);
        check("rst_b_idle", 128'(b_idle), 128'd1);
        next_cycle();
        rst = 1'b0;

        // Single read 0x10 -> 0xA5 visible two cycles after issue
        a_valid = 1; a_addr = 10'h010;
        mid();
        check("t1_sram_req", 128'(a_sram_req), 128'd1);
        check("t1_req_ready", 128'(a_ready), 128'd1);
        check("t1_sram_addr", 128'(a_sram_addr), 128'h10);
        check("t1_rsp_valid_c0", 128'(a_rsp_valid), 128'd0);
        next_cycle();
        a_valid = 0;
        mid();
        check("t1_rsp_valid_c1", 128'(a_rsp_valid), 128'd0);
        check("t1_idle_c1", 128'(a_idle), 128'd0);
        next_cycle();
        a_rsp_ready = 1;
        mid();
        check("t1_rsp_valid_c2", 128'(a_rsp_valid), 128'd1);
        check("t1_rsp_rdata", a_rsp_rdata, 128'hA5);
        next_cycle();
        a_rsp_ready = 0;
        mid();
        check("t1_idle_after_pop", 128'(a_idle), 128'd1);
        check("t1_rsp_valid_after_pop", 128'(a_rsp_valid), 128'd0);

        // Back-to-back reads against a stalled response port
        next_cycle();
        a_valid = 1; a_addr = 10'h020;
        mid();
        check("t2_rd0_ready", 128'(a_ready), 128'd1);
        next_cycle();
        a_addr = 10'h021;
        mid();
        check("t2_rd1_ready", 128'(a_ready), 128'd1);
        next_cycle();
        a_addr = 10'h022;
        mid();
        check("t2_rd2_ready_blocked", 128'(a_ready), 128'd0);
        check("t2_rd2_sram_req_blocked", 128'(a_sram_req), 128'd0);
        check("t2_rsp0_valid", 128'(a_rsp_valid), 128'd1);
        check("t2_rsp0_rdata", a_rsp_rdata, 128'h95);
        next_cycle();
        a_rsp_ready = 1;
        mid();
        check("t2_rd2_blocked_on_pop", 128'(a_ready), 128'd0);
        check("t2_pop0_rdata", a_rsp_rdata, 128'h95);
        next_cycle();
        mid();
        check("t2_rd2_ready_after_pop", 128'(a_ready), 128'd1);
        check("t2_rd2_sram_req", 128'(a_sram_req), 128'd1);
        check("t2_pop1_valid", 128'(a_rsp_valid), 128'd1);
        check("t2_pop1_rdata", a_rsp_rdata, 128'h94);
        next_cycle();
        a_valid = 0;
        mid();
        check("t2_cnt_pop_and_issue", 128'(u_a.cnt_q), 128'd1);
        check("t2_idle_busy", 128'(a_idle), 128'd0);
        check("t2_rsp_gap", 128'(a_rsp_valid), 128'd0);
        next_cycle();
        mid();
        check("t2_pop2_valid", 128'(a_rsp_valid), 128'd1);
        check("t2_pop2_rdata", a_rsp_rdata, 128'h97);
        next_cycle();
        a_rsp_ready = 0;
        mid();
        check("t2_idle_end", 128'(a_idle), 128'd1);

        // Write stalled by gnt for three cycles
        next_cycle();
        a_valid = 1; a_we = 1; a_addr = 10'h030; a_wdata = 128'hDEAD; a_be = '1; a_gnt = 0;
        mid();
        check("t3_sram_req", 128'(a_sram_req), 128'd1);
        check("t3_sram_we", 128'(a_sram_we), 128'd1);
        check("t3_sram_wdata", a_sram_wdata, 128'hDEAD);
        check("t3_sram_be", 128'(a_sram_be), 128'hFFFF);
        check("t3_ready_stall0", 128'(a_ready), 128'd0);
        next_cycle();
        mid();
        check("t3_ready_stall1", 128'(a_ready), 128'd0);
        next_cycle();
        mid();
        check("t3_ready_stall2", 128'(a_ready), 128'd0);
        next_cycle();
        a_gnt = 1;
        mid();
        check("t3_ready_granted", 128'(a_ready), 128'd1);
        next_cycle();
        a_valid = 0; a_we = 0;
        mid();
        check("t3_cnt", 128'(u_a.cnt_q), 128'd0);
        check("t3_idle", 128'(a_idle), 128'd1);
        next_cycle();
        mid();
        check("t3_no_rsp", 128'(a_rsp_valid), 128'd0);

        // Reset while two reads are in flight
        next_cycle();
        a_valid = 1; a_addr = 10'h040;
        mid();
        check("t5_rd0_ready", 128'(a_ready), 128'd1);
        next_cycle();
        a_addr = 10'h041;
        mid();
        check("t5_rd1_ready", 128'(a_ready), 128'd1);
        #1;
        rst = 1; a_valid = 0;
        #1;
        check("t5_rst_rsp_valid", 128'(a_rsp_valid), 128'd0);
        check("t5_rst_idle", 128'(a_idle), 128'd1);
        next_cycle();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t5_no_rsp_after_rst", 128'(a_rsp_valid), 128'd0);
            check("t5_idle_after_rst", 128'(a_idle), 128'd1);
            next_cycle();
        end

        // Latency 3, depth 4 stream: credit returns the cycle after a pop, so four
        // reads issue, one cycle stalls, then the pattern repeats.
        b_rdy_exp = 9'b111101111;
        b_vld_exp = 13'b1111011110000;
        issued = 0;
        popped = 0;
        b_rsp_ready = 1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            b_valid = (issued < 8);
            b_addr  = 10'(10'h050 + issued);
            mid();
            if (cyc == 0) begin
                check("t4_sram_we", 128'(b_sram_we), 128'd0);
                check("t4_sram_wdata", b_sram_wdata, 128'h1234);
                check("t4_sram_be", 128'(b_sram_be), 128'h00F0);
            end
            if (cyc < 9) check($sformatf("t4_ready_c%0d", cyc), 128'(b_ready), 128'(b_rdy_exp[cyc]));
            check($sformatf("t4_rsp_valid_c%0d", cyc), 128'(b_rsp_valid), 128'(b_vld_exp[cyc]));
            if (b_vld_exp[cyc]) begin
                check($sformatf("t4_rsp_rdata_%0d", popped), b_rsp_rdata, fdata(10'(10'h050 + popped)));
                popped++;
            end
            if (b_valid && b_ready) issued++;
            next_cycle();
        end
        b_valid = 0;
        mid();
        check("t4_issued", 128'(issued), 128'd8);
        check("t4_idle_end", 128'(b_idle), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
